// File: rtl/pu_param.sv
// Parametrised processing unit: sign-magnitude dot product per beat, multi-beat
// accumulation, shift/ReLU/saturate finalise, three-stage valid/ready pipeline.
module pu_param #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned DATA_W = 5,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned SHIFT  = 3,
   parameter int unsigned OUT_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [N_CH*DATA_W-1:0]   x,
   input  logic [N_CH*DATA_W-1:0]   w,
   input  logic                     relu_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out,
   output logic                     out_sat,
   output logic [7:0]               out_beats
);

   localparam int unsigned MW      = DATA_W - 1;
   localparam int unsigned PW      = 2 * MW;
   localparam int unsigned MAG_W   = OUT_W - 1;
   localparam int unsigned MAG_MAX = (1 << MAG_W) - 1;
   localparam int unsigned BEAT_W  = 8;

   logic advance;

   // Stage 1 registers
   logic                    s1_valid_q, s1_last_q, s1_relu_q;
   logic signed [ACC_W-1:0] prod_q [N_CH];
   logic signed [ACC_W-1:0] prod_d [N_CH];

   // Stage 2 registers
   logic signed [ACC_W-1:0] acc_q;
   logic [BEAT_W-1:0]       cnt_q;
   logic                    first_q;
   logic                    s2_valid_q, s2_relu_q;
   logic signed [ACC_W-1:0] s2_sum_q;
   logic [BEAT_W-1:0]       s2_beats_q;

   // Stage 3 registers
   logic                    out_valid_q;
   logic [OUT_W-1:0]        out_q, out_d;
   logic                    out_sat_q, out_sat_d;
   logic [BEAT_W-1:0]       out_beats_q;

   logic signed [ACC_W-1:0] tree_sum, acc_base, sum_d;
   logic [BEAT_W-1:0]       beats_base, beats_d;

   // A stalled output freezes the whole pipeline.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Stage 1: per-channel signed products; a zero magnitude never carries a sign.
   always_comb begin : prod_comb
      logic [PW-1:0]           p_mag;
      logic                    p_neg;
      logic signed [ACC_W-1:0] p_ext;
      p_mag = '0;
      p_neg = 1'b0;
      p_ext = '0;
      for (int i = 0; i < N_CH; i++) begin
         p_mag = PW'(x[i*DATA_W +: MW]) * PW'(w[i*DATA_W +: MW]);
         p_neg = (x[i*DATA_W + MW] ^ w[i*DATA_W + MW]) && (p_mag != '0);
         p_ext = ACC_W'(p_mag);
         prod_d[i] = p_neg ? -p_ext : p_ext;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_relu_q  <= 1'b0;
         for (int i = 0; i < N_CH; i++) prod_q[i] <= '0;
      end else if (advance) begin
         s1_valid_q <= in_valid;
         s1_last_q  <= in_last;
         s1_relu_q  <= relu_en;
         for (int i = 0; i < N_CH; i++) prod_q[i] <= prod_d[i];
      end
   end

   // Stage 2: adder tree plus running accumulator; first beat of a group starts from zero.
   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < N_CH; i++) tree_sum = tree_sum + prod_q[i];
      acc_base   = first_q ? '0 : acc_q;
      sum_d      = acc_base + tree_sum;
      beats_base = first_q ? '0 : cnt_q;
      beats_d    = (beats_base == '1) ? beats_base : beats_base + BEAT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         first_q    <= 1'b1;
         s2_valid_q <= 1'b0;
         s2_relu_q  <= 1'b0;
         s2_sum_q   <= '0;
         s2_beats_q <= '0;
      end else if (advance) begin
         s2_valid_q <= s1_valid_q && s1_last_q;
         if (s1_valid_q) begin
            acc_q   <= sum_d;
            cnt_q   <= beats_d;
            first_q <= s1_last_q;
         end
         if (s1_valid_q && s1_last_q) begin
            s2_sum_q   <= sum_d;
            s2_relu_q  <= s1_relu_q;
            s2_beats_q <= beats_d;
         end
      end
   end

   // Stage 3: floor shift, optional ReLU, symmetric clamp, sign-magnitude encode.
   always_comb begin : fin_comb
      logic signed [ACC_W-1:0] r_shift, r_clip, neg_r, lim, nlim;
      logic [MAG_W-1:0]        mag;
      logic                    neg;
      r_shift   = s2_sum_q >>> SHIFT;
      r_clip    = (s2_relu_q && r_shift[ACC_W-1]) ? '0 : r_shift;
      neg_r     = -r_clip;
      lim       = ACC_W'(MAG_MAX);
      nlim      = -lim;
      mag       = '0;
      neg       = 1'b0;
      out_sat_d = 1'b0;
      if (r_clip > lim) begin
         mag       = MAG_W'(MAG_MAX);
         out_sat_d = 1'b1;
      end else if (r_clip < nlim) begin
         mag       = MAG_W'(MAG_MAX);
         neg       = 1'b1;
         out_sat_d = 1'b1;
      end else if (r_clip[ACC_W-1]) begin
         mag = neg_r[MAG_W-1:0];
         neg = 1'b1;
      end else begin
         mag = r_clip[MAG_W-1:0];
      end
      out_d = {neg, mag};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         out_sat_q   <= 1'b0;
         out_beats_q <= '0;
      end else if (advance) begin
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_q       <= out_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= s2_beats_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign out_sat   = out_sat_q;
   assign out_beats = out_beats_q;

endmodule

// File: tb/tb_pu_param.sv
// Randomised and directed bench for pu_param against an arithmetic reference model.
module tb_pu_param;

   localparam int unsigned N_CH = 4;
   localparam int unsigned DW   = 5;
   localparam int unsigned OW   = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid, in_ready, in_last, relu_en;
   logic [N_CH*DW-1:0]   x, w;
   logic                 out_valid, out_ready, out_sat;
   logic [OW-1:0]        out;
   logic [7:0]           out_beats;

   int n_tests = 0;
   int n_fail  = 0;

   logic [13:0] exp_q[$];
   int  m_acc    = 0;
   int  m_beats  = 0;
   int  n_popped = 0;
   bit  accepted;
   bit  seen_valid;

   pu_param dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .x(x), .w(w), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .out_sat(out_sat), .out_beats(out_beats)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int sm2int(input logic [DW-1:0] v);
      return v[DW-1] ? -int'(v[DW-2:0]) : int'(v[DW-2:0]);
   endfunction

   function automatic logic [DW-1:0] enc(input int v);
      int a;
      a = (v < 0) ? -v : v;
      return {v < 0, 4'(a)};
   endfunction

   function automatic logic [N_CH*DW-1:0] pack(input int a, input int b, input int c, input int d);
      return {enc(d), enc(c), enc(b), enc(a)};
   endfunction

   // Expected {beats, sat, out} for a completed group sum, from the arithmetic rules.
   function automatic logic [13:0] expect_word(input int s, input bit relu, input int beats);
      logic signed [15:0] s16;
      int r, mag;
      bit sat;
      s16 = 16'(s);
      r   = int'(s16) >>> 3;
      if (relu && r < 0) r = 0;
      mag = (r < 0) ? -r : r;
      sat = (mag > 15);
      if (sat) mag = 15;
      return {8'(beats), sat, r < 0, 4'(mag)};
   endfunction

   task automatic model_beat();
      for (int i = 0; i < N_CH; i++)
         m_acc += sm2int(x[i*DW +: DW]) * sm2int(w[i*DW +: DW]);
      if (m_beats < 255) m_beats++;
      if (in_last) begin
         exp_q.push_back(expect_word(m_acc, relu_en, m_beats));
         m_acc   = 0;
         m_beats = 0;
      end
   endtask

   // One clock: check output at negedge, track handshakes, return at posedge+1.
   task automatic cycle();
      @(negedge clk);
      if (out_valid) begin
         if (exp_q.size() == 0) check_eq("spurious_valid", out_valid, 1'b0);
         else check_eq("result", {out_beats, out_sat, out}, exp_q[0]);
         if (out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_popped++;
         end
      end
      seen_valid = out_valid;
      accepted   = in_valid && in_ready;
      if (accepted) model_beat();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N_CH*DW-1:0] xv, input logic [N_CH*DW-1:0] wv,
                       input bit last, input bit relu);
      int n;
      x = xv; w = wv; in_last = last; relu_en = relu; in_valid = 1'b1;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!accepted && n < 50);
      if (!accepted) check_eq("send_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      repeat (8) cycle();
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_acc   = 0;
      m_beats = 0;
   endtask

   initial begin
      int n, p0;
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; relu_en = 1'b0;
      x = '0; w = '0; out_ready = 1'b1;
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out", out, 5'd0);
      check_eq("rst_out_beats", out_beats, 8'd0);
      check_eq("rst_out_sat", out_sat, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Single-beat group and its latency.
      send(pack(3, 2, 1, 4), pack(2, 3, 5, 1), 1'b1, 1'b0);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!seen_valid && n < 10);
      check_eq("latency", 32'(n), 32'd3);
      drain();

      // Negative saturation with and without ReLU.
      send(pack(15, 0, 0, 0), pack(-15, 0, 0, 0), 1'b1, 1'b0);
      send(pack(15, 0, 0, 0), pack(-15, 0, 0, 0), 1'b1, 1'b1);
      drain();

      // Two-beat group with a bubble in between.
      send(pack(4, 0, 0, 0), pack(4, 0, 0, 0), 1'b0, 1'b0);
      cycle();
      send(pack(4, 0, 0, 0), pack(4, 0, 0, 0), 1'b1, 1'b0);
      drain();

      // Negative-zero inputs must encode +0.
      send({4{5'b10000}}, pack(5, 5, 5, 5), 1'b1, 1'b0);
      drain();

      // Backpressure: three groups queued behind a stalled output.
      p0 = n_popped;
      out_ready = 1'b0;
      send(pack(1, 2, 3, 4), pack(4, 3, 2, 1), 1'b1, 1'b0);
      send(pack(-7, 7, 0, 0), pack(7, 7, 0, 0), 1'b1, 1'b0);
      send(pack(15, 15, 15, 15), pack(15, 15, 15, 15), 1'b1, 1'b0);
      repeat (5) begin
         cycle();
         check_eq("bp_in_ready", in_ready, 1'b0);
         check_eq("bp_out_valid", out_valid, 1'b1);
      end
      drain();
      check_eq("bp_results", 32'(n_popped - p0), 32'd3);

      // Reset mid-group while an output is stalled.
      out_ready = 1'b0;
      send(pack(7, 0, 0, 0), pack(7, 0, 0, 0), 1'b0, 1'b0);
      send(pack(2, 0, 0, 0), pack(2, 0, 0, 0), 1'b1, 1'b0);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!seen_valid && n < 10);
      rst = 1'b0;
      #1;
      check_eq("async_rst_out_valid", out_valid, 1'b0);
      check_eq("async_rst_out", out, 5'd0);
      check_eq("async_rst_in_ready", in_ready, 1'b1);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      out_ready = 1'b1;
      send(pack(1, 0, 0, 0), pack(8, 0, 0, 0), 1'b1, 1'b0);
      drain();

      // Beat counter saturation over a 260-beat group.
      for (int b = 0; b < 260; b++)
         send(pack(1, 0, 0, 0), pack(1, 0, 0, 0), (b == 259), 1'b0);
      drain();

      // Random traffic with random backpressure.
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_last   = ($urandom_range(0, 2) == 0);
         relu_en   = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N_CH; i++) begin
            x[i*DW +: DW] = 5'($urandom_range(0, 31));
            w[i*DW +: DW] = 5'($urandom_range(0, 31));
         end
         cycle();
      end
      in_valid = 1'b1;
      in_last  = 1'b1;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!accepted && n < 50);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pu_param.md
# pu_param

Parametrised processing unit for the neural-network datapath. It computes a signed dot product of `N_CH` sign-magnitude inputs and weights per beat, and can accumulate over several beats to form one neuron sum. The result is scaled by an arithmetic right shift, optionally ReLU-clipped, and saturated to a sign-magnitude output. A three-stage valid/ready pipeline feeds the next layer or the MaxNet stage.

## Interface
Parameters:
- `N_CH`, 4, channels (x/w pairs) per beat; ≥1.
- `DATA_W`, 5, width of each x and w; MSB is the sign, the low `DATA_W-1` bits are the magnitude.
- `ACC_W`, 16, two's-complement accumulator width.
- `SHIFT`, 3, arithmetic right shift applied to the final sum.
- `OUT_W`, 5, output width in sign-magnitude.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_last`  in  1  beat closes the current neuron group.
- `x`  in  `N_CH*DATA_W`  inputs; channel i at `[i*DATA_W +: DATA_W]`.
- `w`  in  `N_CH*DATA_W`  weights; same packing as `x`.
- `relu_en`  in  1  clip negative results to 0; sampled with the last beat of the group.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  `OUT_W`  sign-magnitude result.
- `out_sat`  out  1  result was clipped by saturation.
- `out_beats`  out  8  number of beats in the group; saturates at 255.

## Operation
- Beat acceptance: a beat is accepted on a rising edge with `in_valid && in_ready`.
- Stage 1 (products), per channel:
  - magnitude = mag(x)·mag(w), width `2*(DATA_W-1)`.
  - sign = sign(x) XOR sign(w).
  - A zero magnitude always yields +0, so −0 inputs are legal.
  - Each product is converted to two's complement and sign-extended to `ACC_W`.
  - Stage 1 registers the products together with valid, last and relu_en.
- Stage 2 (accumulate):
  - The adder tree sums the `N_CH` products.
  - `acc <= (first ? 0 : acc) + tree_sum`. `first` is set by reset and after every last beat.
  - The beat counter increments, saturating at 255.
  - A bubble (stage-1 valid=0) changes neither `acc` nor the counter.
- Stage 3 (finalise), on a last beat only:
  - `r = (acc + tree_sum) >>> SHIFT`, floor rounding.
  - If `relu_en` and r<0, then r=0.
  - Clamp |r| to `2^(OUT_W-1)-1`; `out_sat`=1 iff clamping changed the value.
  - Encode as sign-magnitude. A zero result is always encoded +0.
  - Register `out`, `out_sat`, `out_beats`; set `out_valid`. `acc` and the counter restart for the next group.
- Non-last beats never produce an output.
- Accumulator overflow wraps in two's complement and is not flagged. The integrator sizes `ACC_W` for `2*(DATA_W-1)+clog2(N_CH)+clog2(max beats)+1`.
- Stall:
  - `advance = !out_valid || out_ready`, and `in_ready = advance`.
  - All stages hold when `advance`=0.
  - A result leaves on an edge with `out_valid && out_ready`. A new result may load on the same edge, giving full throughput.
- Reset (`rst`=0, any time, including mid-group):
  - `out_valid`=0, `out`=0, `out_sat`=0, `out_beats`=0, all stage valids 0, `acc`=0, `first`=1.
  - `in_ready`=1 while `rst` is low and after release.
  - A partially accumulated group is discarded.

## Timing
- Latency: a last beat accepted on edge E gives `out_valid`=1 after edge E+2, i.e. visible in the cycle after the third rising edge counting E.
- Throughput: one beat per cycle when `out_ready`=1. Back-to-back single-beat groups give one result per cycle.
- Stall: while `out_valid && !out_ready`, `in_ready`=0. `out`, `out_sat` and `out_beats` stay stable and no accepted beat is lost or reordered.
- `in_ready` is combinational from `out_valid`/`out_ready`. No other combinational input-to-output path exists.
- Asynchronous reset assertion clears all outputs immediately, with no clock required.

## Test plan
Defaults apply unless stated; values are sign-magnitude.
- Single-beat group: x=(+3,+2,+1,+4), w=(+2,+3,+5,+1), in_last=1 → sum 21, 21>>>3=2 → `out`=5'b00010, `out_sat`=0, `out_beats`=1, `out_valid` after edge E+2.
- Negative with saturation: x=(+15,0,0,0), w=(−15,0,0,0), last, relu_en=0 → −225>>>3=−29 → `out`=5'b11111, `out_sat`=1. Same stimulus with relu_en=1 → `out`=0, `out_sat`=0.
- Two-beat group: beat 1 x=(+4,0,0,0), w=(+4,0,0,0), in_last=0; beat 2 identical with in_last=1; bubble between them → sum 32 → `out`=5'b00100, `out_beats`=2. Exactly one `out_valid` pulse.
- Backpressure: hold `out_ready`=0 for 5 cycles while streaming 3 single-beat groups → `in_ready`=0 while output is full and `out` stable. After release, results arrive in order with none dropped or duplicated.
- Reset mid-group: accept beat (+7·+7, in_last=0), pulse `rst` low for 1 cycle, then send x=(+1,0,0,0), w=(+8,0,0,0), last → `out`=5'b00001, `out_beats`=1. The discarded beat does not contaminate the result.
- −0 handling: x=(−0,−0,−0,−0), w=(+5,+5,+5,+5), last → `out`=5'b00000 (+0), `out_sat`=0.
